instruction_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_ifid_reg.sv | 39 +++
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED,
        FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_ifid_reg.sv
// rtl/fetch_ifid_reg.sv - IF/ID pipeline register with load, hold and flush
module fetch_ifid_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   flush,
    input  logic [INSTR_WIDTH-1:0] load_instr,
    input  logic [ADDR_WIDTH-1:0]  load_pc,
    input  logic [ADDR_WIDTH-1:0]  load_pc_plus4,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [ADDR_WIDTH-1:0]  ifid_pc,
    output logic [ADDR_WIDTH-1:0]  ifid_pc_plus4,
    output logic                   ifid_valid
);

    // Flush outranks load; with neither asserted the register holds (stall).
    // A flush only clears instr/valid: the pc fields are meaningless while invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc       <= '0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else if (flush) begin
            ifid_instr    <= NOP_INSTR;
            ifid_valid    <= 1'b0;
        end else if (load) begin
            ifid_instr    <= load_instr;
            ifid_pc       <= load_pc;
            ifid_pc_plus4 <= load_pc_plus4;
            ifid_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program counter, fetch FSM and IF/ID capture
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                      ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0,
    parameter int unsigned             MEM_BYTES  = 2**26,
    parameter logic [INSTR_WIDTH-1:0]  HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [ADDR_WIDTH-1:0]  ifid_pc,
    output logic [ADDR_WIDTH-1:0]  ifid_pc_plus4,
    output logic                   ifid_valid,
    output logic                   halted,
    output logic                   fault
);

    // Highest address from which a full word can still be fetched.
    localparam logic [ADDR_WIDTH-1:0] MAX_PC = ADDR_WIDTH'(MEM_BYTES - 4);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  redirect_ok;
    logic                  ifid_load;
    logic                  ifid_flush;

    assign imem_addr   = pc_q;
    assign pc_plus4    = pc_q + ADDR_WIDTH'(4);
    assign redirect_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= MAX_PC);
    assign halted      = (state_q == HALTED);
    assign fault       = (state_q == FAULT);

    // State and pc registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next pc and IF/ID control. Redirect comes from an older
    // instruction, so it beats both stall and whatever word is being fetched.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    if (redirect_ok) pc_d = redirect_pc;
                    else             state_d = FAULT;
                end else if (!stall) begin
                    if (pc_q > MAX_PC) begin
                        ifid_flush = 1'b1;
                        state_d    = FAULT;
                    end else begin
                        ifid_load = 1'b1;
                        if (imem_data == HALT_INSTR) state_d = HALTED;
                        else                         pc_d    = pc_plus4;
                    end
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    if (redirect_ok) begin
                        pc_d    = redirect_pc;
                        state_d = RUN;
                    end else begin
                        state_d = FAULT;
                    end
                end else if (!stall) begin
                    ifid_flush = 1'b1;
                end
            end
            FAULT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                state_d    = FAULT;
                ifid_flush = 1'b1;
            end
        endcase
    end

    fetch_ifid_reg #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ifid (
        .clk           (clk),
        .reset         (reset),
        .load          (ifid_load),
        .flush         (ifid_flush),
        .load_instr    (imem_data),
        .load_pc       (pc_q),
        .load_pc_plus4 (pc_plus4),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam logic [31:0] MAXPC = 32'h03FF_FFFC;
    localparam int ST_BOOT  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_HALT  = 2;
    localparam int ST_FAULT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_data;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;
    logic        ifid_valid, halted, fault;

    logic        s_reset;
    logic [31:0] s_imem_addr, s_imem_data;
    logic [31:0] s_ifid_instr, s_ifid_pc, s_ifid_pc_plus4;
    logic        s_ifid_valid, s_halted, s_fault;

    logic [31:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    int          m_st;
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
    logic        m_valid;

    always #5 clk = ~clk;

    assign imem_data   = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]]
                                                : ({imem_addr[31:2], 2'b00} ^ 32'h13);
    assign s_imem_data = (s_imem_addr < 32'd1024) ? mem[s_imem_addr[9:2]]
                                                  : ({s_imem_addr[31:2], 2'b00} ^ 32'h13);

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .ifid_valid     (ifid_valid),
        .halted         (halted),
        .fault          (fault)
    );

    instruction_fetch #(.MEM_BYTES(64)) dut_small (
        .clk            (clk),
        .reset          (s_reset),
        .imem_addr      (s_imem_addr),
        .imem_data      (s_imem_data),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .ifid_instr     (s_ifid_instr),
        .ifid_pc        (s_ifid_pc),
        .ifid_pc_plus4  (s_ifid_pc_plus4),
        .ifid_valid     (s_ifid_valid),
        .halted         (s_halted),
        .fault          (s_fault)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd1024) return mem[a[9:2]];
        return {a[31:2], 2'b00} ^ 32'h13;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if (w == HALT) w = 32'h2000_0000;
        return w;
    endfunction

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a <= MAXPC);
    endfunction

    task automatic model_reset();
        m_st = ST_BOOT; m_pc = 32'h0;
        m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_bubble();
        m_valid = 1'b0;
        m_instr = 32'h0;
    endtask

    // Expected effect of the coming clock edge given the current inputs.
    task automatic model_step();
        logic [31:0] w;
        w = mem_word(m_pc);
        case (m_st)
            ST_BOOT: m_st = ST_RUN;
            ST_RUN: begin
                if (redirect_valid) begin
                    model_bubble();
                    if (legal(redirect_pc)) m_pc = redirect_pc;
                    else                    m_st = ST_FAULT;
                end else if (!stall) begin
                    if (m_pc > MAXPC) begin
                        model_bubble();
                        m_st = ST_FAULT;
                    end else begin
                        m_instr = w; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_valid = 1'b1;
                        if (w == HALT) m_st = ST_HALT;
                        else           m_pc = m_pc + 32'd4;
                    end
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    model_bubble();
                    if (legal(redirect_pc)) begin
                        m_pc = redirect_pc;
                        m_st = ST_RUN;
                    end else begin
                        m_st = ST_FAULT;
                    end
                end else if (!stall) begin
                    model_bubble();
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".addr"},   imem_addr,     m_pc);
        check({tag, ".valid"},  ifid_valid,    m_valid);
        check({tag, ".instr"},  ifid_instr,    m_instr);
        if (m_valid) begin
            check({tag, ".pc"},  ifid_pc,       m_ipc);
            check({tag, ".pc4"}, ifid_pc_plus4, m_ipc4);
        end
        check({tag, ".halted"}, halted, m_st == ST_HALT);
        check({tag, ".fault"},  fault,  m_st == ST_FAULT);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_target();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0:       return {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            1:       return 32'h0400_0000 + 32'($urandom_range(0, 63) * 4);
            2:       return MAXPC - 32'($urandom_range(0, 3) * 4);
            default: return 32'($urandom_range(0, 255) * 4);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0007;
        reset = 1'b1; s_reset = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk); @(negedge clk);

        // Small memory: sequential fetch runs into the end and faults.
        s_reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check("small.boot_valid", s_ifid_valid, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); @(negedge clk);
            check("small.valid", s_ifid_valid, 1'b1);
            check("small.pc",    s_ifid_pc, 32'(k * 4));
            check("small.instr", s_ifid_instr, mem[k]);
        end
        @(posedge clk); @(negedge clk);
        check("small.fault",     s_fault, 1'b1);
        check("small.end_valid", s_ifid_valid, 1'b0);
        check("small.end_addr",  s_imem_addr, 32'd64);
        @(posedge clk); @(negedge clk);
        check("small.fault_addr", s_imem_addr, 32'd64);
        s_reset = 1'b1;

        // Directed sequence on the default-size instance.
        model_reset();
        compare_all("reset");
        reset = 1'b0;
        tick("boot");
        check("boot.valid", ifid_valid, 1'b0);
        tick("f0");
        check("f0.instr", ifid_instr, 32'h2008_0005);
        check("f0.pc4",   ifid_pc_plus4, 32'd4);
        tick("f4");
        check("f4.instr", ifid_instr, 32'h2009_0007);
        check("f4.pc4",   ifid_pc_plus4, 32'd8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall.addr", imem_addr, 32'd8);
            check("stall.pc",   ifid_pc, 32'd4);
        end
        stall = 1'b0;
        tick("after_stall");
        check("after_stall.pc", ifid_pc, 32'd8);
        tick("fc");
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick("redir");
        check("redir.valid", ifid_valid, 1'b0);
        check("redir.addr",  imem_addr, 32'h40);
        stall = 1'b0; redirect_valid = 1'b0;
        tick("f40");
        check("f40.pc",    ifid_pc, 32'h40);
        check("f40.instr", ifid_instr, mem[16]);

        mem[3] = HALT;
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick("to0");
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick("run_to_halt");
        check("halt.halted", halted, 1'b1);
        check("halt.instr",  ifid_instr, HALT);
        check("halt.valid",  ifid_valid, 1'b1);
        check("halt.addr",   imem_addr, 32'h0C);
        tick("halt_bubble");
        check("halt_bubble.valid", ifid_valid, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick("resume");
        check("resume.halted", halted, 1'b0);
        redirect_valid = 1'b0;
        tick("f20");
        check("f20.pc", ifid_pc, 32'h20);
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick("misalign");
        check("misalign.fault", fault, 1'b1);
        redirect_pc = 32'h0;
        tick("fault_ignore");
        check("fault_ignore.fault", fault, 1'b1);
        redirect_valid = 1'b0;
        do_reset();
        check("reset.addr", imem_addr, 32'h0);

        // Randomized phase against the reference model.
        for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 7) == 0) ? HALT : rand_word();
        for (int c = 0; c < 600; c++) begin
            if (m_st == ST_FAULT && $urandom_range(0, 3) == 0) begin
                redirect_valid = 1'b0; stall = 1'b0;
                do_reset();
            end else begin
                stall          = ($urandom_range(0, 3) == 0);
                redirect_valid = ($urandom_range(0, 9) == 0) ||
                                 (m_st == ST_HALT && $urandom_range(0, 2) == 0);
                redirect_pc    = rand_target();
                tick("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
